// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
// State names, opcode values and datapath mux encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        RWB,
        BEQ,
        BNE,
        JUMP,
        ADDIEX,
        ADDIWB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcWriteCondN;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word decoder.
// Anything not named for a state stays 0.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.iorD     = 1'b0;
                ctrl.aluSrcA  = 1'b0;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PC_ALU;
                ctrl.irWrite  = 1'b1;
                ctrl.pcWrite  = 1'b1;
            end
            DECODE: begin
                ctrl.aluSrcA = 1'b0;
                ctrl.aluSrcB = SRCB_BR;
                ctrl.aluOp   = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
                ctrl.regDst   = 1'b0;
            end
            MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluOp   = ALU_FUNCT;
            end
            RWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
                ctrl.memtoReg = 1'b0;
            end
            BEQ, BNE: begin
                ctrl.aluSrcA      = 1'b1;
                ctrl.aluSrcB      = SRCB_RT;
                ctrl.aluOp        = ALU_SUB;
                ctrl.pcSource     = PC_ALUOUT;
                ctrl.pcWriteCond  = (state == BEQ);
                ctrl.pcWriteCondN = (state == BNE);
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PC_JUMP;
            end
            ADDIWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b0;
                ctrl.memtoReg = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic
// and memory-ready stall gating around the control word decoder.
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit SUPPORT_ADDI = 1'b1,
    parameter bit SUPPORT_BNE  = 1'b1,
    parameter bit MEM_WAIT_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondN,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegalOp
);

    state_t state;
    state_t nextState;
    ctrl_t  ctrl;
    logic   memDone;
    logic   fetchGate;
    logic   isLoadStore;
    logic   isAddi;
    logic   isBne;
    logic   illegal;

    assign memDone     = !MEM_WAIT_EN || memReady;
    assign isLoadStore = (opCode == OP_LW) || (opCode == OP_SW);
    assign isAddi      = SUPPORT_ADDI && (opCode == OP_ADDI);
    assign isBne       = SUPPORT_BNE && (opCode == OP_BNE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = IDLE;
        illegal   = 1'b0;
        case (state)
            IDLE:   nextState = FETCH;
            FETCH:  nextState = memDone ? DECODE : FETCH;
            DECODE: begin
                unique case (1'b1)
                    isLoadStore:         nextState = MEMADR;
                    opCode == OP_RTYPE:  nextState = EXEC;
                    opCode == OP_BEQ:    nextState = BEQ;
                    isBne:               nextState = BNE;
                    opCode == OP_J:      nextState = JUMP;
                    isAddi:              nextState = ADDIEX;
                    default: begin
                        nextState = FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            MEMADR: nextState = (opCode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nextState = memDone ? MEMWB : MEMRD;
            MEMWB:  nextState = FETCH;
            MEMWR:  nextState = memDone ? FETCH : MEMWR;
            EXEC:   nextState = RWB;
            RWB:    nextState = FETCH;
            BEQ:    nextState = FETCH;
            BNE:    nextState = FETCH;
            JUMP:   nextState = FETCH;
            ADDIEX: nextState = ADDIWB;
            ADDIWB: nextState = FETCH;
            default: nextState = IDLE;
        endcase
    end

    mc_ctrl_decode uDecode (
        .state (state),
        .ctrl  (ctrl)
    );

    // A stalled fetch keeps the read going but must not load IR or PC yet.
    assign fetchGate = (state != FETCH) || memDone;

    assign PCWrite      = ctrl.pcWrite && fetchGate;
    assign IRWrite      = ctrl.irWrite && fetchGate;
    assign PCWriteCond  = ctrl.pcWriteCond;
    assign PCWriteCondN = ctrl.pcWriteCondN;
    assign IorD         = ctrl.iorD;
    assign MemRead      = ctrl.memRead;
    assign MemWrite     = ctrl.memWrite;
    assign MemtoReg     = ctrl.memtoReg;
    assign RegDst       = ctrl.regDst;
    assign RegWrite     = ctrl.regWrite;
    assign ALUSrcA      = ctrl.aluSrcA;
    assign ALUSrcB      = ctrl.aluSrcB;
    assign ALUOp        = ctrl.aluOp;
    assign PCSource     = ctrl.pcSource;
    assign illegalOp    = illegal;

endmodule
